pin_id_uart_tx: RTL and testbench

- Parametrised board-bring-up beacon: repeatedly transmits a fixed ASCII pin/net identifier as standard 8N1-style UART frames on one output pin.
- Adds a baud-rate divider, configurable string length, optional CR/LF terminator, configurable stop bits, an inter-message idle gap, an enable input and status outputs.
- One instance per probed pin; output goes straight to the FPGA pad for a scope or USB-UART dongle.

---
 rtl/pin_id_uart_tx_if.sv | 14 +
 rtl/pin_id_uart_tx.sv | 138 +++++++++++++
 tb/tb_pin_id_uart_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_id_uart_tx_if.sv
// Signal bundle for the pin identifier UART beacon.
//   en       : run enable, driven by the controller (master)
//   out      : UART TX line, idle high, driven by the beacon (slave)
//   busy     : high from start bit through final stop bit of a message
//   msg_done : one-cycle pulse after the final stop bit of a message
interface pin_id_uart_tx_if;
  logic en;
  logic out;
  logic busy;
  logic msg_done;

  modport master (output en, input out, input busy, input msg_done);
  modport slave  (input en, output out, output busy, output msg_done);
endinterface

// File: rtl/pin_id_uart_tx.sv
// Board-bring-up beacon: repeatedly sends a fixed ASCII identifier (with
// optional CR/LF) as 8N1-style UART frames, followed by an idle gap.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : pin_id_uart_tx_if.slave (en in; out, busy, msg_done out)
module pin_id_uart_tx #(
  parameter logic [127:0] NAME         = "AB12",
  parameter int unsigned  NUM_CHARS    = 4,
  parameter int unsigned  CLKS_PER_BIT = 16,
  parameter int unsigned  STOP_BITS    = 1,
  parameter int unsigned  APPEND_CRLF  = 1,
  parameter int unsigned  GAP_BITS     = 24
) (
  input  logic            clk,
  input  logic            rst,
  pin_id_uart_tx_if.slave bus
);

  if (NUM_CHARS < 1 || NUM_CHARS > 16 || CLKS_PER_BIT < 1 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("pin_id_uart_tx: illegal parameter set");
  end

  localparam int unsigned MSG_LEN = NUM_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_MAX = (GAP_BITS > STOP_BITS) ? GAP_BITS : STOP_BITS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [4:0]        CHAR_LAST = 5'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;   // data bit within the character
  logic [CNT_W-1:0]  cnt;       // stop-bit or gap-bit counter
  logic [4:0]        char_idx;
  logic              out_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_wrap;
  logic [7:0]        cur_byte;

  assign baud_wrap = (baud == BAUD_LAST);

  // Character 0 sits in the most-significant used byte of NAME; CR and LF
  // follow the name. Everything here folds to constants per char_idx.
  always_comb begin
    cur_byte = 8'h0A;
    if (char_idx < 5'(NUM_CHARS))
      cur_byte = 8'(NAME >> (8 * (NUM_CHARS - 1 - 32'(char_idx))));
    else if (char_idx == 5'(NUM_CHARS))
      cur_byte = 8'h0D;
  end

  // out is registered, so each transition loads the level of the bit that
  // the next state will present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      char_idx <= '0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE)
        baud <= baud_wrap ? '0 : baud + 1'b1;
      unique case (state)
        IDLE: begin
          out_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.en) begin
            state    <= START;
            char_idx <= '0;
            baud     <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
            out_q   <= cur_byte[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              cnt   <= '0;
              out_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              out_q   <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (cnt != STOP_LAST) begin
              cnt <= cnt + 1'b1;
            end else if (char_idx != CHAR_LAST) begin
              char_idx <= char_idx + 5'd1;
              state    <= START;
              out_q    <= 1'b0;
            end else begin
              cnt    <= '0;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= (GAP_BITS == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (baud_wrap) begin
            if (cnt == GAP_LAST) state <= IDLE;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.msg_done = done_q;

endmodule

// File: tb/tb_pin_id_uart_tx.sv
// Self-checking bench for pin_id_uart_tx: three instances (default string at
// 4 clk/bit, single-char "X" at 1 clk/bit without CRLF or gap, and two stop
// bits at 2 clk/bit) compared cycle by cycle against a timing model.
module tb_pin_id_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pin_id_uart_tx_if if_a ();
  pin_id_uart_tx_if if_b ();
  pin_id_uart_tx_if if_c ();

  pin_id_uart_tx #(.NAME("AB12"), .NUM_CHARS(4), .CLKS_PER_BIT(4),
                   .STOP_BITS(1), .APPEND_CRLF(1), .GAP_BITS(24))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));

  pin_id_uart_tx #(.NAME("X"), .NUM_CHARS(1), .CLKS_PER_BIT(1),
                   .STOP_BITS(1), .APPEND_CRLF(0), .GAP_BITS(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  pin_id_uart_tx #(.NAME("AB12"), .NUM_CHARS(4), .CLKS_PER_BIT(2),
                   .STOP_BITS(2), .APPEND_CRLF(1), .GAP_BITS(24))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int n_chk  = 0;
  int n_fail = 0;

  // per-instance configuration: clocks/bit, stop bits, gap bits, message length
  int cpb_t [3] = '{4, 1, 2};
  int sb_t  [3] = '{1, 1, 2};
  int gap_t [3] = '{24, 0, 24};
  int len_t [3] = '{6, 1, 6};

  bit         tr  [$];
  logic [7:0] dec [$];
  int         ferr;

  function automatic logic [7:0] get_char(int inst, int ch);
    logic [7:0] tbl [6];
    tbl = '{8'h41, 8'h42, 8'h31, 8'h32, 8'h0D, 8'h0A};
    if (inst == 1) return 8'h58;
    return tbl[ch];
  endfunction

  function automatic int frame_cyc(int i); return (9 + sb_t[i]) * cpb_t[i]; endfunction
  function automatic int msg_cyc(int i);   return len_t[i] * frame_cyc(i); endfunction
  function automatic int period(int i);    return msg_cyc(i) + gap_t[i] * cpb_t[i] + 1; endfunction

  // k = cycles since the idle cycle in which en was first seen high.
  // nmsg = number of messages en allows (0 = unlimited).
  function automatic logic m_out(int i, int k, int nmsg);
    int p, kk, ch, b;
    logic [7:0] c;
    p = period(i);
    if (nmsg > 0 && k >= nmsg * p) return 1'b1;
    kk = k % p;
    if (kk == 0 || kk > msg_cyc(i)) return 1'b1;
    kk = kk - 1;
    ch = kk / frame_cyc(i);
    b  = (kk % frame_cyc(i)) / cpb_t[i];
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      c = get_char(i, ch);
      return c[b-1];
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy(int i, int k, int nmsg);
    int p, kk;
    p = period(i);
    if (nmsg > 0 && k >= nmsg * p) return 1'b0;
    kk = k % p;
    return (kk >= 1 && kk <= msg_cyc(i));
  endfunction

  function automatic logic m_done(int i, int k, int nmsg);
    int d;
    d = k - msg_cyc(i) - 1;
    if (d < 0 || (d % period(i)) != 0) return 1'b0;
    if (nmsg > 0 && d / period(i) >= nmsg) return 1'b0;
    return 1'b1;
  endfunction

  // Independent UART receiver over the recorded line trace.
  task automatic decode_trace(input int cpb, input int sb);
    int t;
    logic [7:0] b;
    dec.delete();
    ferr = 0;
    t = 1;
    while (t < tr.size()) begin
      if (tr[t-1] == 1'b1 && tr[t] == 1'b0) begin
        if (t + (9 + sb) * cpb > tr.size()) break;
        for (int j = 0; j < 8; j++) b[j] = tr[t + (j + 1) * cpb + cpb / 2];
        for (int s = 0; s < sb; s++)
          if (tr[t + (9 + s) * cpb + cpb / 2] != 1'b1) ferr++;
        dec.push_back(b);
        t = t + (9 + sb) * cpb;
      end else begin
        t++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all(input logic ea, input logic eb, input logic ec);
    rst = 1'b1;
    if_a.en = ea; if_b.en = eb; if_c.en = ec;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if_a.en = 1'($urandom_range(0, 1));
      if_b.en = 1'($urandom_range(0, 1));
      if_c.en = 1'($urandom_range(0, 1));
      step();
      if (c >= 1) begin
        n_chk++;
        if ({if_a.out, if_a.busy, if_a.msg_done} !== 3'b100) begin
          n_fail++; $display("FAIL reset_a c=%0d got %b exp 100", c, {if_a.out, if_a.busy, if_a.msg_done});
        end
        n_chk++;
        if ({if_b.out, if_b.busy, if_b.msg_done} !== 3'b100) begin
          n_fail++; $display("FAIL reset_b c=%0d got %b exp 100", c, {if_b.out, if_b.busy, if_b.msg_done});
        end
        n_chk++;
        if ({if_c.out, if_c.busy, if_c.msg_done} !== 3'b100) begin
          n_fail++; $display("FAIL reset_c c=%0d got %b exp 100", c, {if_c.out, if_c.busy, if_c.msg_done});
        end
      end
    end
  endtask

  task automatic test_en_low();
    reset_all(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      n_chk++;
      if ({if_a.out, if_a.busy, if_a.msg_done} !== 3'b100) begin
        n_fail++; $display("FAIL en_low_a k=%0d got %b exp 100", k, {if_a.out, if_a.busy, if_a.msg_done});
      end
      n_chk++;
      if ({if_b.out, if_b.busy, if_b.msg_done} !== 3'b100) begin
        n_fail++; $display("FAIL en_low_b k=%0d got %b exp 100", k, {if_b.out, if_b.busy, if_b.msg_done});
      end
      n_chk++;
      if ({if_c.out, if_c.busy, if_c.msg_done} !== 3'b100) begin
        n_fail++; $display("FAIL en_low_c k=%0d got %b exp 100", k, {if_c.out, if_c.busy, if_c.msg_done});
      end
      step();
    end
  endtask

  task automatic test_default_msg();
    int p, dones, first_done, starts[$];
    logic prev_busy;
    p = period(0);
    reset_all(1'b1, 1'b0, 1'b0);
    tr.delete();
    dones = 0; first_done = -1; prev_busy = 1'b0;
    for (int k = 0; k < 2 * p + 5; k++) begin
      tr.push_back(if_a.out);
      n_chk++;
      if (if_a.out !== m_out(0, k, 0)) begin
        n_fail++; $display("FAIL default_out k=%0d got %b exp %b", k, if_a.out, m_out(0, k, 0));
      end
      n_chk++;
      if (if_a.busy !== m_busy(0, k, 0)) begin
        n_fail++; $display("FAIL default_busy k=%0d got %b exp %b", k, if_a.busy, m_busy(0, k, 0));
      end
      n_chk++;
      if (if_a.msg_done !== m_done(0, k, 0)) begin
        n_fail++; $display("FAIL default_done k=%0d got %b exp %b", k, if_a.msg_done, m_done(0, k, 0));
      end
      if (if_a.msg_done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
      if (if_a.busy === 1'b1 && prev_busy === 1'b0) starts.push_back(k);
      prev_busy = if_a.busy;
      step();
    end
    n_chk++;
    if (first_done != 241) begin
      n_fail++; $display("FAIL default_done_cycle got %0d exp 241", first_done);
    end
    n_chk++;
    if (starts.size() < 2 || starts[0] != 1 || starts[1] != 338) begin
      n_fail++; $display("FAIL default_start_cycles got n=%0d first=%0d second=%0d exp 1 338",
                         starts.size(), (starts.size() > 0) ? starts[0] : -1,
                         (starts.size() > 1) ? starts[1] : -1);
    end
    n_chk++;
    if (dones != 2) begin
      n_fail++; $display("FAIL default_done_count got %0d exp 2", dones);
    end
    decode_trace(4, 1);
    n_chk++;
    if (dec.size() != 12 || ferr != 0) begin
      n_fail++; $display("FAIL default_decode_count got %0d bytes %0d ferr exp 12 0", dec.size(), ferr);
    end
    for (int i = 0; i < dec.size(); i++) begin
      n_chk++;
      if (dec[i] !== get_char(0, i % 6)) begin
        n_fail++; $display("FAIL default_byte i=%0d got %h exp %h", i, dec[i], get_char(0, i % 6));
      end
    end
  endtask

  task automatic test_en_drop();
    int p, kd;
    p  = period(0);
    kd = 1 + 2 * frame_cyc(0) + int'($urandom_range(0, frame_cyc(0) - 1));
    reset_all(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < p + 300; k++) begin
      n_chk++;
      if ({if_a.out, if_a.busy, if_a.msg_done} !== {m_out(0, k, 1), m_busy(0, k, 1), m_done(0, k, 1)}) begin
        n_fail++; $display("FAIL en_drop k=%0d kd=%0d got %b exp %b", k, kd,
                           {if_a.out, if_a.busy, if_a.msg_done},
                           {m_out(0, k, 1), m_busy(0, k, 1), m_done(0, k, 1)});
      end
      if (k == kd) if_a.en = 1'b0;
      step();
    end
    if_a.en = 1'b1;
    for (int k = 0; k < 2 * frame_cyc(0) + 10; k++) begin
      n_chk++;
      if ({if_a.out, if_a.busy, if_a.msg_done} !== {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)}) begin
        n_fail++; $display("FAIL en_restart k=%0d got %b exp %b", k,
                           {if_a.out, if_a.busy, if_a.msg_done},
                           {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int kr, dones;
    kr = 1 + frame_cyc(0) + 4 * cpb_t[0] + int'($urandom_range(0, cpb_t[0] - 1));
    reset_all(1'b1, 1'b0, 1'b0);
    dones = 0;
    for (int k = 0; k <= kr; k++) begin
      n_chk++;
      if ({if_a.out, if_a.busy, if_a.msg_done} !== {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)}) begin
        n_fail++; $display("FAIL pre_abort k=%0d got %b exp %b", k,
                           {if_a.out, if_a.busy, if_a.msg_done},
                           {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)});
      end
      if (k < kr) step();
    end
    rst = 1'b1;
    step();
    n_chk++;
    if ({if_a.out, if_a.busy, if_a.msg_done} !== 3'b100) begin
      n_fail++; $display("FAIL abort_state kr=%0d got %b exp 100", kr, {if_a.out, if_a.busy, if_a.msg_done});
    end
    rst = 1'b0;
    for (int k = 0; k < msg_cyc(0) + 20; k++) begin
      n_chk++;
      if ({if_a.out, if_a.busy, if_a.msg_done} !== {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)}) begin
        n_fail++; $display("FAIL post_abort k=%0d got %b exp %b", k,
                           {if_a.out, if_a.busy, if_a.msg_done},
                           {m_out(0, k, 0), m_busy(0, k, 0), m_done(0, k, 0)});
      end
      if (if_a.msg_done === 1'b1) dones++;
      step();
    end
    n_chk++;
    if (dones != 1) begin
      n_fail++; $display("FAIL abort_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_short();
    int low, starts[$];
    logic prev_busy;
    reset_all(1'b0, 1'b1, 1'b0);
    tr.delete();
    low = 0; prev_busy = 1'b0;
    for (int k = 0; k <= 55; k++) begin
      tr.push_back(if_b.out);
      n_chk++;
      if ({if_b.out, if_b.busy, if_b.msg_done} !== {m_out(1, k, 0), m_busy(1, k, 0), m_done(1, k, 0)}) begin
        n_fail++; $display("FAIL short k=%0d got %b exp %b", k,
                           {if_b.out, if_b.busy, if_b.msg_done},
                           {m_out(1, k, 0), m_busy(1, k, 0), m_done(1, k, 0)});
      end
      if (k >= 1 && if_b.busy === 1'b0) low++;
      if (if_b.busy === 1'b1 && prev_busy === 1'b0) starts.push_back(k);
      prev_busy = if_b.busy;
      step();
    end
    n_chk++;
    if (low != 5) begin
      n_fail++; $display("FAIL short_busy_low got %0d exp 5", low);
    end
    for (int i = 1; i < starts.size(); i++) begin
      n_chk++;
      if (starts[i] - starts[i-1] != 11) begin
        n_fail++; $display("FAIL short_spacing i=%0d got %0d exp 11", i, starts[i] - starts[i-1]);
      end
    end
    decode_trace(1, 1);
    n_chk++;
    if (dec.size() != 5 || ferr != 0) begin
      n_fail++; $display("FAIL short_decode_count got %0d bytes %0d ferr exp 5 0", dec.size(), ferr);
    end
    for (int i = 0; i < dec.size(); i++) begin
      n_chk++;
      if (dec[i] !== 8'h58) begin
        n_fail++; $display("FAIL short_byte i=%0d got %h exp 58", i, dec[i]);
      end
    end
  endtask

  task automatic test_stop2();
    int p, busy_hi;
    p = period(2);
    reset_all(1'b0, 1'b0, 1'b1);
    tr.delete();
    busy_hi = 0;
    for (int k = 0; k < 2 * p + 5; k++) begin
      tr.push_back(if_c.out);
      n_chk++;
      if ({if_c.out, if_c.busy, if_c.msg_done} !== {m_out(2, k, 0), m_busy(2, k, 0), m_done(2, k, 0)}) begin
        n_fail++; $display("FAIL stop2 k=%0d got %b exp %b", k,
                           {if_c.out, if_c.busy, if_c.msg_done},
                           {m_out(2, k, 0), m_busy(2, k, 0), m_done(2, k, 0)});
      end
      if (k < p && if_c.busy === 1'b1) busy_hi++;
      step();
    end
    n_chk++;
    if (busy_hi != 6 * 22) begin
      n_fail++; $display("FAIL stop2_msg_len got %0d exp %0d", busy_hi, 6 * 22);
    end
    decode_trace(2, 2);
    n_chk++;
    if (dec.size() != 12 || ferr != 0) begin
      n_fail++; $display("FAIL stop2_decode got %0d bytes %0d ferr exp 12 0", dec.size(), ferr);
    end
    for (int i = 0; i < dec.size(); i++) begin
      n_chk++;
      if (dec[i] !== get_char(2, i % 6)) begin
        n_fail++; $display("FAIL stop2_byte i=%0d got %h exp %h", i, dec[i], get_char(2, i % 6));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.en = 1'b0; if_b.en = 1'b0; if_c.en = 1'b0;
    test_reset();
    test_en_low();
    test_default_msg();
    test_en_drop();
    test_reset_mid();
    test_short();
    test_stop2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
